// File: rtl/regport_rr_arbiter.sv
// Round-robin arbiter for the shared 16-way register write port: grants one requester at a time,
// drives the select index and enable of the 4-to-16 decoder, with hold timeout and a one-cycle gap.
module regport_rr_arbiter #(
   parameter int unsigned UUID     = 0,
   parameter string       NAME     = "",
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Request,
   input  logic        Release,
   input  logic        Stall,
   output logic        Grant_Valid,
   output logic [3:0]  Grant_Index,
   output logic        Preempt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HoldLimit  = 8'(MAX_HOLD);
   localparam bit         HoldActive = (MAX_HOLD != 0);

   state_t      state_q;
   logic [3:0]  ptr_q;
   logic [7:0]  hold_q;
   logic        valid_q;
   logic [3:0]  idx_q;
   logic        preempt_q;

   logic [3:0]  winnerIdx;
   logic        anyReq;
   logic        otherReq;
   logic        ownerReq;
   logic        holdExpired;

   // Scan downward so the last hit is the first set bit at or after the rotation pointer.
   always_comb begin
      winnerIdx = ptr_q;
      for (int i = 15; i >= 0; i--) begin
         if (Request[ptr_q + 4'(i)]) begin
            winnerIdx = ptr_q + 4'(i);
         end
      end
   end

   assign anyReq      = |Request;
   assign ownerReq    = Request[idx_q];
   assign otherReq    = |(Request & ~(16'b1 << idx_q));
   assign holdExpired = HoldActive && (hold_q >= HoldLimit);

   // Stall blocks new grants and the timeout path, but a release or withdrawal still ends the grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 4'd0;
         hold_q    <= 8'd0;
         valid_q   <= 1'b0;
         idx_q     <= 4'd0;
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_GAP: begin
               if (!Stall && anyReq) begin
                  state_q <= ST_GRANT;
                  valid_q <= 1'b1;
                  idx_q   <= winnerIdx;
                  hold_q  <= 8'd1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (Release || !ownerReq) begin
                  state_q <= ST_GAP;
                  valid_q <= 1'b0;
                  ptr_q   <= idx_q + 4'd1;
               end else if (holdExpired && !Stall && otherReq) begin
                  state_q   <= ST_GAP;
                  valid_q   <= 1'b0;
                  ptr_q     <= idx_q + 4'd1;
                  preempt_q <= 1'b1;
               end else if (!Stall && (hold_q != 8'hFF)) begin
                  hold_q <= hold_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign Grant_Valid = valid_q;
   assign Grant_Index = idx_q;
   assign Preempt     = preempt_q;

endmodule
